arp_requester: RTL and testbench

- Initiator side of the ARP link: on a request for a target IPv4 address it transmits an Ethernet/ARP request (broadcast, OPER=1) on the byte-wide TX stream.
- It then parses the RX byte stream for the matching ARP reply (OPER=2) and returns the resolved MAC.
- It retransmits on timeout and gives up after a bounded number of retries.
- It sits beside the ARP responder on the same MAC byte streams, feeding the host's address-resolution cache.

---
 rtl/arp_requester.sv | 206 ++++++++++++++++++++
 tb/tb_arp_requester.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_requester.sv
// ARP initiator: sends a broadcast ARP request for a target IPv4 and returns the MAC from the matching reply.
// Optional macro ARP_TX_PAD_EN pads the transmitted frame to 60 bytes with zeros.
module arp_requester #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        req_valid_i,
  input  logic [31:0] req_ipv4_i,
  output logic        req_ready_o,
  input  logic [47:0] my_mac_i,
  input  logic [31:0] my_ipv4_i,
  input  logic [7:0]  data_rx_i,
  input  logic        data_valid_rx_i,
  output logic [7:0]  data_tx_o,
  output logic        data_valid_tx_o,
  input  logic        data_ack_tx_i,
  output logic        resolved_valid_o,
  output logic [47:0] resolved_mac_o,
  output logic [31:0] resolved_ipv4_o,
  output logic        timeout_o,
  output logic        busy_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
`ifdef ARP_TX_PAD_EN
  localparam int FRAME_LEN = 60;
`else
  localparam int FRAME_LEN = 42;
`endif
  localparam logic [5:0]    LAST_IDX   = 6'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t        state_q;
  logic [5:0]    tx_idx_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic [31:0]   target_q;
  logic [RW-1:0] retry_q;
  logic [TW-1:0] timer_q;
  logic          res_valid_q;
  logic [47:0]   res_mac_q;
  logic [31:0]   res_ip_q;
  logic          timeout_q;
  logic [5:0]    rx_cnt_q;
  logic          rx_ok_q;
  logic          rx_ok_d;
  logic [47:0]   sha_q;
  logic          rx_match;
  logic [7:0]    tx_next;

  function automatic logic [7:0] tx_byte(input logic [5:0] idx, input logic [47:0] mac,
                                         input logic [31:0] ip, input logic [31:0] tgt);
    int k;
    logic [7:0] b;
    k = int'(idx);
    b = 8'h00;
    case (k) inside
      [0:5]:   b = 8'hFF;
      [6:11]:  b = mac[8*(11-k) +: 8];
      12:      b = 8'h08;
      13:      b = 8'h06;
      15:      b = 8'h01;
      16:      b = 8'h08;
      18:      b = 8'h06;
      19:      b = 8'h04;
      21:      b = 8'h01;
      [22:27]: b = mac[8*(27-k) +: 8];
      [28:31]: b = ip[8*(31-k) +: 8];
      [38:41]: b = tgt[8*(41-k) +: 8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Per-position reply check; positions not listed (src MAC, SHA, TPA) are don't-care.
  function automatic logic rx_byte_ok(input logic [5:0] idx, input logic [7:0] d,
                                      input logic [47:0] mac, input logic [31:0] tgt);
    int k;
    logic ok;
    k = int'(idx);
    ok = 1'b1;
    case (k) inside
      [0:5]:   ok = (d == mac[8*(5-k) +: 8]);
      12:      ok = (d == 8'h08);
      13:      ok = (d == 8'h06);
      14:      ok = (d == 8'h00);
      15:      ok = (d == 8'h01);
      16:      ok = (d == 8'h08);
      17:      ok = (d == 8'h00);
      18:      ok = (d == 8'h06);
      19:      ok = (d == 8'h04);
      20:      ok = (d == 8'h00);
      21:      ok = (d == 8'h02);
      [28:31]: ok = (d == tgt[8*(31-k) +: 8]);
      [32:37]: ok = (d == mac[8*(37-k) +: 8]);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  always_comb begin
    rx_ok_d  = ((rx_cnt_q == 6'd0) ? 1'b1 : rx_ok_q)
               & rx_byte_ok(rx_cnt_q, data_rx_i, my_mac_i, target_q);
    rx_match = data_valid_rx_i && (rx_cnt_q == 6'd41) && rx_ok_d;
    tx_next  = tx_byte(tx_idx_q + 6'd1, my_mac_i, my_ipv4_i, target_q);
  end

  // RX parser: counts bytes of each contiguous valid run, saturating at 42 so padding/FCS is ignored.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      rx_cnt_q <= 6'd0;
      rx_ok_q  <= 1'b0;
      sha_q    <= 48'd0;
    end else if (!data_valid_rx_i) begin
      rx_cnt_q <= 6'd0;
    end else if (rx_cnt_q != 6'd42) begin
      rx_cnt_q <= rx_cnt_q + 6'd1;
      rx_ok_q  <= rx_ok_d;
      if (rx_cnt_q >= 6'd22 && rx_cnt_q <= 6'd27) sha_q <= {sha_q[39:0], data_rx_i};
    end
  end

  // TX stream: a byte transfers on a cycle with valid & ack; valid never depends on ack,
  // and data is held stable until the transfer.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= S_IDLE;
      tx_idx_q    <= 6'd0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      target_q    <= 32'd0;
      retry_q     <= '0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      res_mac_q   <= 48'd0;
      res_ip_q    <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            target_q   <= req_ipv4_i;
            retry_q    <= '0;
            tx_idx_q   <= 6'd0;
            tx_data_q  <= 8'hFF;
            tx_valid_q <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          if (data_ack_tx_i) begin
            if (tx_idx_q == LAST_IDX) begin
              tx_valid_q <= 1'b0;
              timer_q    <= '0;
              state_q    <= S_WAIT;
            end else begin
              tx_idx_q  <= tx_idx_q + 6'd1;
              tx_data_q <= tx_next;
            end
          end
        end
        S_WAIT: begin
          // A reply landing on the timeout cycle takes priority over retry/give-up.
          if (rx_match) begin
            res_valid_q <= 1'b1;
            res_mac_q   <= sha_q;
            res_ip_q    <= target_q;
            state_q     <= S_IDLE;
          end else if (timer_q == TIMER_LAST) begin
            if (retry_q == RETRY_MAX) begin
              timeout_q <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              retry_q    <= retry_q + 1'b1;
              tx_idx_q   <= 6'd0;
              tx_data_q  <= 8'hFF;
              tx_valid_q <= 1'b1;
              state_q    <= S_SEND;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o      = (state_q == S_IDLE);
  assign busy_o           = (state_q != S_IDLE);
  assign data_tx_o        = tx_data_q;
  assign data_valid_tx_o  = tx_valid_q;
  assign resolved_valid_o = res_valid_q;
  assign resolved_mac_o   = res_mac_q;
  assign resolved_ipv4_o  = res_ip_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_arp_requester.sv
// Directed bench for arp_requester built with TIMEOUT_CYCLES=100, MAX_RETRIES=2.
module tb_arp_requester;

`ifdef ARP_TX_PAD_EN
  localparam int N = 60;
`else
  localparam int N = 42;
`endif

  logic        clk;
  logic        areset;
  logic        req_valid_i;
  logic [31:0] req_ipv4_i;
  logic        req_ready_o;
  logic [47:0] my_mac_i;
  logic [31:0] my_ipv4_i;
  logic [7:0]  data_rx_i;
  logic        data_valid_rx_i;
  logic [7:0]  data_tx_o;
  logic        data_valid_tx_o;
  logic        data_ack_tx_i;
  logic        resolved_valid_o;
  logic [47:0] resolved_mac_o;
  logic [31:0] resolved_ipv4_o;
  logic        timeout_o;
  logic        busy_o;

  arp_requester #(.TIMEOUT_CYCLES(100), .MAX_RETRIES(2)) dut (
    .clk(clk), .areset(areset),
    .req_valid_i(req_valid_i), .req_ipv4_i(req_ipv4_i), .req_ready_o(req_ready_o),
    .my_mac_i(my_mac_i), .my_ipv4_i(my_ipv4_i),
    .data_rx_i(data_rx_i), .data_valid_rx_i(data_valid_rx_i),
    .data_tx_o(data_tx_o), .data_valid_tx_o(data_valid_tx_o), .data_ack_tx_i(data_ack_tx_i),
    .resolved_valid_o(resolved_valid_o), .resolved_mac_o(resolved_mac_o),
    .resolved_ipv4_o(resolved_ipv4_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  int t_drop = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_frame [0:59];
  logic [7:0] exp_frame [0:41] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
    8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
    8'hC0, 8'hA8, 8'h01, 8'h0A,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'hC0, 8'hA8, 8'h01, 8'h14};

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push_frame();
    for (int i = 0; i < N; i++) exp_q.push_back((i < 42) ? exp_frame[i] : 8'h00);
  endtask

  task automatic request();
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    check("req_ready_low", req_ready_o, 1'b0);
    check("tx_valid_first", data_valid_tx_o, 1'b1);
    check("tx_first_byte", data_tx_o, 8'hFF);
  endtask

  // Consumes the frame in flight; ack on the last of every ack_period cycles.
  task automatic capture_frame(input int ack_period);
    int n;
    int cyc;
    logic [7:0] prev;
    bit have_prev;
    n = 0;
    cyc = 0;
    have_prev = 0;
    prev = 8'h00;
    while (data_valid_tx_o && cyc < 400) begin
      data_ack_tx_i = (ack_period == 1) ? 1'b1 : ((cyc % ack_period) == ack_period - 1);
      if (have_prev) check("tx_stable", data_tx_o, prev);
      if (data_ack_tx_i) begin
        check("tx_byte", data_tx_o, (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx);
        n++;
        have_prev = 0;
      end else begin
        prev = data_tx_o;
        have_prev = 1;
      end
      tick();
      cyc++;
    end
    data_ack_tx_i = 1'b1;
    check("tx_frame_len", n, N);
    check("tx_busy_after", busy_o, 1'b1);
    exp_q.delete();
    t_drop = cycle;
  endtask

  task automatic build_reply(input logic [47:0] sha, input logic [15:0] oper, input logic [31:0] spa);
    logic [47:0] own;
    logic [31:0] tpa;
    own = 48'h020000000001;
    tpa = 32'hC0A8010A;
    for (int i = 0; i < 60; i++) rx_frame[i] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      rx_frame[k]      = own[47-8*k -: 8];
      rx_frame[6+k]    = sha[47-8*k -: 8];
      rx_frame[22+k]   = sha[47-8*k -: 8];
      rx_frame[32+k]   = own[47-8*k -: 8];
    end
    rx_frame[12] = 8'h08; rx_frame[13] = 8'h06;
    rx_frame[14] = 8'h00; rx_frame[15] = 8'h01;
    rx_frame[16] = 8'h08; rx_frame[17] = 8'h00;
    rx_frame[18] = 8'h06; rx_frame[19] = 8'h04;
    rx_frame[20] = oper[15:8]; rx_frame[21] = oper[7:0];
    for (int k = 0; k < 4; k++) begin
      rx_frame[28+k] = spa[31-8*k -: 8];
      rx_frame[38+k] = tpa[31-8*k -: 8];
    end
  endtask

  task automatic send_rx(input int len, output int pulses, output int pos);
    pulses = 0;
    pos = -1;
    for (int i = 0; i < len; i++) begin
      data_rx_i = rx_frame[i];
      data_valid_rx_i = 1'b1;
      tick();
      if (resolved_valid_o) begin pulses++; if (pos < 0) pos = i; end
    end
    data_valid_rx_i = 1'b0;
    data_rx_i = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resolved_valid_o) begin pulses++; if (pos < 0) pos = len + i; end
    end
  endtask

  task automatic wait_tx_gap(input string tag);
    int guard;
    guard = 0;
    while (!data_valid_tx_o && guard < 400) begin tick(); guard++; end
    check(tag, cycle - t_drop, 100);
  endtask

  int pulses, pos, guard, tmo_seen;

  initial begin
    areset = 1'b0;
    req_valid_i = 1'b0;
    req_ipv4_i = 32'hC0A80114;
    my_mac_i = 48'h020000000001;
    my_ipv4_i = 32'hC0A8010A;
    data_rx_i = 8'h00;
    data_valid_rx_i = 1'b0;
    data_ack_tx_i = 1'b1;
    repeat (3) tick();
    check("rst_tx_valid", data_valid_tx_o, 1'b0);
    check("rst_tx_data", data_tx_o, 8'h00);
    check("rst_res_valid", resolved_valid_o, 1'b0);
    check("rst_res_mac", resolved_mac_o, 48'h0);
    check("rst_res_ip", resolved_ipv4_o, 32'h0);
    check("rst_timeout", timeout_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ready", req_ready_o, 1'b1);
    areset = 1'b1;
    tick();

    // Frame with ack held high, then a valid reply in WAIT.
    request();
    push_frame();
    capture_frame(1);
    build_reply(48'h021122334455, 16'h0002, 32'hC0A80114);
    send_rx(42, pulses, pos);
    check("reply_pulses", pulses, 1);
    check("reply_pulse_pos", pos, 41);
    check("reply_mac", resolved_mac_o, 48'h021122334455);
    check("reply_ip", resolved_ipv4_o, 32'hC0A80114);
    check("reply_busy", busy_o, 1'b0);
    check("reply_ready", req_ready_o, 1'b1);

    // Ack every third cycle; bad replies ignored; two retries then a timeout.
    request();
    push_frame();
    capture_frame(3);
    build_reply(48'h021122334455, 16'h0001, 32'hC0A80114);
    send_rx(42, pulses, pos);
    check("oper1_ignored", pulses, 0);
    build_reply(48'h021122334455, 16'h0002, 32'hC0A80115);
    send_rx(42, pulses, pos);
    check("spa_ignored", pulses, 0);
    wait_tx_gap("retry1_gap");
    push_frame();
    capture_frame(1);
    wait_tx_gap("retry2_gap");
    push_frame();
    capture_frame(1);
    guard = 0;
    while (!timeout_o && guard < 400) begin tick(); guard++; end
    check("timeout_gap", cycle - t_drop, 100);
    check("timeout_busy", busy_o, 1'b0);
    tmo_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (timeout_o || data_valid_tx_o) tmo_seen++;
    end
    check("timeout_single", tmo_seen, 0);
    check("timeout_ready", req_ready_o, 1'b1);
    check("timeout_mac_held", resolved_mac_o, 48'h021122334455);

    // Truncated reply, then valid reply with 18 pad bytes.
    request();
    push_frame();
    capture_frame(1);
    build_reply(48'h0A0B0C0D0E0F, 16'h0002, 32'hC0A80114);
    send_rx(20, pulses, pos);
    check("trunc_ignored", pulses, 0);
    send_rx(60, pulses, pos);
    check("padded_pulses", pulses, 1);
    check("padded_pos", pos, 41);
    check("padded_mac", resolved_mac_o, 48'h0A0B0C0D0E0F);

    // Reply arriving while stalled in SEND is discarded.
    data_ack_tx_i = 1'b0;
    request();
    build_reply(48'h021122334455, 16'h0002, 32'hC0A80114);
    send_rx(42, pulses, pos);
    check("send_reply_ignored", pulses, 0);
    check("send_stall_valid", data_valid_tx_o, 1'b1);
    check("send_stall_data", data_tx_o, 8'hFF);
    push_frame();
    capture_frame(1);
    send_rx(42, pulses, pos);
    check("after_stall_resolve", pulses, 1);
    check("after_stall_mac", resolved_mac_o, 48'h021122334455);

    // Reset in the middle of a frame.
    request();
    repeat (10) tick();
    areset = 1'b0;
    #1;
    check("midrst_tx_valid", data_valid_tx_o, 1'b0);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_mac", resolved_mac_o, 48'h0);
    tick();
    tick();
    areset = 1'b1;
    tick();
    check("midrst_ready", req_ready_o, 1'b1);
    request();
    push_frame();
    capture_frame(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
